// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encoding and
// counter sizing helper.
package sumador_pkg;

    localparam logic [1:0] EST_REPOSO  = 2'd0;
    localparam logic [1:0] EST_SUMANDO = 2'd1;
    localparam logic [1:0] EST_FIN     = 2'd2;

    // Bit counter needs clog2(width) bits, but never fewer than one.
    function automatic int ancho_contador(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/sumador_completo.sv
// One-bit full adder used as the single arithmetic cell of the serial adder.
module sumador_completo (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/sumador_serie.sv
// Bit-serial adder/subtractor: latches operands on start, adds one bit per
// clock LSB first, then reports S/Cout/desb with a one-cycle done pulse.
module sumador_serie
    import sumador_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resta,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             desb,
    output logic             busy,
    output logic             done
);

    localparam int             CW      = ancho_contador(WIDTH);
    localparam logic [CW-1:0]  CNT_FIN = CW'(WIDTH - 1);

    logic [1:0]       estado_q, estado_d;
    logic [WIDTH-1:0] regA_q, regA_d;
    logic [WIDTH-1:0] regB_q, regB_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] S_q, S_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             Cout_q, Cout_d;
    logic             desb_q, desb_d;
    logic             bit_s, bit_c;

    sumador_completo u_celda (
        .a    (regA_q[0]),
        .b    (regB_q[0]),
        .cin  (carry_q),
        .s    (bit_s),
        .cout (bit_c)
    );

    always_comb begin
        estado_d = estado_q;
        regA_d   = regA_q;
        regB_d   = regB_q;
        acc_d    = acc_q;
        S_d      = S_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        Cout_d   = Cout_q;
        desb_d   = desb_q;
        case (estado_q)
            EST_REPOSO: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B and seed the carry.
                    regA_d   = A;
                    regB_d   = resta ? ~B : B;
                    carry_d  = resta;
                    cnt_d    = '0;
                    estado_d = EST_SUMANDO;
                end
            end
            EST_SUMANDO: begin
                carry_d            = bit_c;
                acc_d              = acc_q >> 1;
                acc_d[WIDTH-1]     = bit_s;
                regA_d             = regA_q >> 1;
                regB_d             = regB_q >> 1;
                cnt_d              = cnt_q + CW'(1);
                if (cnt_q == CNT_FIN) begin
                    // carry_q is still the carry into the MSB at this point.
                    cnt_d    = cnt_q;
                    S_d      = acc_d;
                    Cout_d   = bit_c;
                    desb_d   = carry_q ^ bit_c;
                    estado_d = EST_FIN;
                end
            end
            EST_FIN: estado_d = EST_REPOSO;
            default: estado_d = EST_REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= EST_REPOSO;
            regA_q   <= '0;
            regB_q   <= '0;
            acc_q    <= '0;
            S_q      <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            Cout_q   <= 1'b0;
            desb_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            regA_q   <= regA_d;
            regB_q   <= regB_d;
            acc_q    <= acc_d;
            S_q      <= S_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            Cout_q   <= Cout_d;
            desb_q   <= desb_d;
        end
    end

    assign S    = S_q;
    assign Cout = Cout_q;
    assign desb = desb_q;
    assign busy = (estado_q == EST_SUMANDO);
    assign done = (estado_q == EST_FIN);

endmodule

// File: tb/tb_sumador_serie.sv
// Bench for sumador_serie: directed operations on an 8-bit and a 1-bit
// instance, checked every cycle against an integer-arithmetic model.
module tb_sumador_serie;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, resta8 = 1'b0;
    logic [7:0] A8 = '0, B8 = '0, S8;
    logic       Cout8, desb8, busy8, done8;
    logic       start1 = 1'b0, resta1 = 1'b0;
    logic [0:0] A1 = '0, B1 = '0, S1;
    logic       Cout1, desb1, busy1, done1;

    int   checks = 0;
    int   errors = 0;
    logic rst_q = 1'b0;
    bit   armed = 1'b0;
    res_t q8[$];
    res_t q1[$];
    res_t last8 = '0;
    res_t last1 = '0;

    always #5 clk = ~clk;

    sumador_serie #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .resta(resta8), .A(A8), .B(B8),
        .S(S8), .Cout(Cout8), .desb(desb8), .busy(busy8), .done(done8)
    );

    sumador_serie #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .resta(resta1), .A(A1), .B(B1),
        .S(S1), .Cout(Cout1), .desb(desb1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed/unsigned integer view of the operation, independent of how the
    // hardware serialises it.
    function automatic res_t calc(input int w, input int a_in, input int b_in, input bit r);
        int   m, h, a, b, sa, sb, t;
        res_t x;
        m    = 1 << w;
        h    = m / 2;
        a    = a_in & (m - 1);
        b    = b_in & (m - 1);
        sa   = (a >= h) ? a - m : a;
        sb   = (b >= h) ? b - m : b;
        t    = r ? sa - sb : sa + sb;
        x.v  = (t < -h) || (t > h - 1);
        x.c  = r ? (a >= b) : (a + b >= m);
        x.s  = 8'((r ? a - b : a + b) & (m - 1));
        return x;
    endfunction

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        res_t e;
        if (rst_q) begin
            q8.delete();
            q1.delete();
            last8 = '0;
            last1 = '0;
            armed = 1'b1;
            chk("reset8", 32'({S8, Cout8, desb8, busy8, done8}), 32'd0);
            chk("reset1", 32'({S1, Cout1, desb1, busy1, done1}), 32'd0);
        end else if (armed) begin
            if (done8) begin
                if (q8.size() == 0) chk("done8_unexpected", 32'd1, 32'd0);
                else begin
                    e = q8.pop_front();
                    chk("result8", 32'({S8, Cout8, desb8}), 32'(e));
                    last8 = e;
                end
            end else chk("hold8", 32'({S8, Cout8, desb8}), 32'(last8));
            if (done1) begin
                if (q1.size() == 0) chk("done1_unexpected", 32'd1, 32'd0);
                else begin
                    e = q1.pop_front();
                    chk("result1", 32'({7'd0, S1, Cout1, desb1}), 32'(e));
                    last1 = e;
                end
            end else chk("hold1", 32'({7'd0, S1, Cout1, desb1}), 32'(last1));
        end
    end

    // Called just after a rising edge; start is sampled at the next edge (e0).
    task automatic op(input bit w1, input logic [7:0] a, input logic [7:0] b,
                      input bit r, input bit pulse);
        int w, nb, dc;
        w = w1 ? 1 : 8;
        if (w1) begin A1 = a[0:0]; B1 = b[0:0]; resta1 = r; start1 = 1'b1; end
        else    begin A8 = a;      B8 = b;      resta8 = r; start8 = 1'b1; end
        @(posedge clk); #1;
        if (w1) begin
            q1.push_back(calc(1, int'(a), int'(b), r));
            start1 = 1'b0; A1 = ~A1; B1 = ~B1; resta1 = ~resta1;
        end else begin
            q8.push_back(calc(8, int'(a), int'(b), r));
            start8 = 1'b0; A8 = ~a; B8 = a ^ b; resta8 = ~r;
        end
        nb = 0;
        dc = -1;
        for (int c = 1; c <= w + 4 && dc < 0; c++) begin
            @(negedge clk);
            if (w1 ? busy1 : busy8) nb++;
            if (w1 ? done1 : done8) dc = c;
            if (pulse) begin
                if (c == 2 || c == 8) begin start8 = 1'b1; A8 = 8'hFF; B8 = 8'hFF; resta8 = 1'b0; end
                if (c == 3) start8 = 1'b0;
            end
        end
        chk(w1 ? "busy_cycles1" : "busy_cycles8", 32'(nb), 32'(w));
        chk(w1 ? "done_cycle1" : "done_cycle8", 32'(dc), 32'(w + 1));
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    initial begin
        // Hand-computed values pin the model.
        chk("model_5A_3C", 32'(calc(8, 'h5A, 'h3C, 0)), 32'({8'h96, 1'b0, 1'b1}));
        chk("model_FF_01", 32'(calc(8, 'hFF, 'h01, 0)), 32'({8'h00, 1'b1, 1'b0}));
        chk("model_10m20", 32'(calc(8, 'h10, 'h20, 1)), 32'({8'hF0, 1'b0, 1'b0}));
        chk("model_80m01", 32'(calc(8, 'h80, 'h01, 1)), 32'({8'h7F, 1'b1, 1'b1}));
        chk("model_7Fm7F", 32'(calc(8, 'h7F, 'h7F, 1)), 32'({8'h00, 1'b1, 1'b0}));
        chk("model_11_22", 32'(calc(8, 'h11, 'h22, 0)), 32'({8'h33, 1'b0, 1'b0}));
        chk("model_0F_01", 32'(calc(8, 'h0F, 'h01, 0)), 32'({8'h10, 1'b0, 1'b0}));
        chk("model_w1_11", 32'(calc(1, 1, 1, 0)),       32'({8'h00, 1'b1, 1'b1}));

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0);
        op(1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
        op(1'b0, 8'h10, 8'h20, 1'b1, 1'b0);
        op(1'b0, 8'h80, 8'h01, 1'b1, 1'b0);
        op(1'b0, 8'h7F, 8'h7F, 1'b1, 1'b0);

        op(1'b0, 8'h11, 8'h22, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_rerun_busy", 32'(busy8), 32'd0);
        end
        @(posedge clk); #1;

        // Abort an operation with reset in cycle 4, restart right after release.
        A8 = 8'h0F; B8 = 8'h01; resta8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        for (int c = 1; c <= 4; c++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        op(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++)
            op(1'b1, 8'(i & 1), 8'((i >> 1) & 1), i[2], 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("queue8_drained", 32'(q8.size()), 32'd0);
        chk("queue1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
